boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Power-up and restart controller for the 7-step CPU. It holds the CPU in reset and copies `PROG_LEN` bytes from the program ROM into CPU RAM through the init port: MAR load, then RAM write, one stepper slot each, aligned to the CPU's own stepper clock. It then releases the CPU and watches run time with a step-count watchdog. It sits between the ROM and `cpu_b`, replacing hand-timed testbench resets.

## Interface
- `PROG_LEN`, 16: bytes to load (1..256).
- `WATCHDOG`, 1024: stepper cycles allowed in RUN before `timeout` (≥1).
- `in_clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start` in 1: one-cycle pulse; begins (or restarts) the boot sequence.
- `step_clk` in 1: CPU stepper clock, synchronous to `in_clk`.
- `rom_addr` out 8: ROM read address. ROM is combinational (data valid the same cycle).
- `rom_data` in 8: ROM byte at `rom_addr`.
- `cpu_reset` out 1: active-high reset to CPU.
- `loading_ram` out 1: selects init port inside CPU.
- `set_mar_init` out 1: MAR load strobe.
- `addr_init` out 8: address for MAR.
- `set_ram_init` out 1: RAM write strobe.
- `instr_from_rom` out 8: byte for RAM.
- `busy` out 1: high in SYNC/MAR/RAM.
- `done` out 1: high in RUN.
- `timeout` out 1: sticky watchdog flag.

## Operation
- Slot boundary: `step_rise = step_clk & ~step_q`, with `step_q` registered; one slot is one stepper cycle.
- States: IDLE, SYNC, MAR, RAM, RUN.
- IDLE: `cpu_reset`=1, all strobes 0. On `start`, go to SYNC, index k=0, clear `timeout`.
- SYNC: wait for `step_rise`, then go to MAR.
- MAR: `loading_ram`=1, `set_mar_init`=1, `addr_init`=k for the whole slot. At `step_rise`, go to RAM.
- RAM: `loading_ram`=1, `set_ram_init`=1, `addr_init`=k, `rom_addr`=k, `instr_from_rom`=`rom_data` for the whole slot. At `step_rise`:
  - if k=`PROG_LEN`-1, go to RUN;
  - else k+1, go to MAR.
- RUN: `cpu_reset`=0, `loading_ram`=0, `done`=1. Watchdog counter wd increments on each `step_rise`. When wd reaches `WATCHDOG`:
  - set `timeout`=1;
  - assert `cpu_reset`=1;
  - go to IDLE.
- `start` in any non-IDLE state aborts: strobes drop next cycle, then restart at SYNC with k=0 and wd=0. `cpu_reset` is 1 from the cycle after `start`.
- k is 8 bits and wraps only via the `PROG_LEN` terminal compare. `PROG_LEN`=256 loads addresses 0..255. wd width is clog2(`WATCHDOG`+1).
- `start` and `step_rise` in the same cycle: `start` wins.

## Timing
- Reset values: `cpu_reset`=1, `rom_addr`=0, `addr_init`=0, `instr_from_rom`=0, all other outputs 0, state IDLE, k=0, wd=0, `step_q`=0.
- All outputs are registered; each changes in the cycle after the qualifying `step_rise` or `start`.
- Load latency: `PROG_LEN`×2 slots, plus 0–1 slot of SYNC alignment.
- Strobes are never high together. `loading_ram` is continuous from the first MAR through the last RAM slot.
- Reset low mid-load: outputs take reset values immediately (async). No RAM write is left asserted.

## Structure
- Shared package `boot_pkg`: state encoding constants (IDLE=0, SYNC=1, MAR=2, RAM=3, RUN=4) and the 8-bit address/data width constants used by `cpu_b`.
- One sub-module, `step_edge`: registers `step_clk` and emits the one-cycle `step_rise`. Everything else is a single FSM plus the two counters.

## Test plan
- Reset: hold `reset`=0 with random `step_clk` -> `cpu_reset`=1, all other outputs 0; `start` is ignored while low.
- Full load, `PROG_LEN`=4, ROM = 8'hA1, 8'hB2, 8'hC3, 8'hD4:
  - 8 slots of alternating strobes;
  - MAR slots show `addr_init`=0..3;
  - RAM slots show `instr_from_rom`=A1..D4;
  - then `done`=1 and `cpu_reset`=0.
- Watchdog, `WATCHDOG`=5: after RUN, the 5th `step_rise` -> `timeout`=1, `cpu_reset`=1, IDLE.
- Restart in RUN: `start` -> `done`=0, `cpu_reset`=1 next cycle; reload from k=0 matches the ROM again and `timeout` is cleared.
- Abort mid-load: `start` during RAM slot k=2 -> strobes drop; next MAR shows `addr_init`=0.
- Async reset during RAM slot -> `set_ram_init` falls without waiting for a clock edge.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared constants for the boot sequencer and cpu_b.
// State encoding and 8-bit bus widths.
package boot_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_MAR  = 3'd2,
    ST_RAM  = 3'd3,
    ST_RUN  = 3'd4
  } boot_state_e;

endpackage

// File: rtl/boot_sequencer_step_edge.sv
// Stepper clock edge detector.
// Emits a one-cycle pulse on each step_clk rising edge.
module step_edge (
  input  logic clk,
  input  logic reset,
  input  logic step_clk,
  output logic step_rise
);

  logic step_q;
  logic step_d;

  assign step_d    = step_clk;
  assign step_rise = step_clk & ~step_q;

  // Remember last stepper level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step_d;
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads ROM into CPU RAM,
// releases the CPU, then guards it with a watchdog.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int PROG_LEN = 16,
  parameter int WATCHDOG = 1024
) (
  input  logic              in_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_clk,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              cpu_reset,
  output logic              loading_ram,
  output logic              set_mar_init,
  output logic [ADDR_W-1:0] addr_init,
  output logic              set_ram_init,
  output logic [DATA_W-1:0] instr_from_rom,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int WDW = $clog2(WATCHDOG + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(WATCHDOG - 1);
  localparam logic [ADDR_W-1:0] K_LAST =
    ADDR_W'(PROG_LEN - 1);

  logic step_rise;

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              timeout_q, timeout_d;

  logic              cpu_reset_q, cpu_reset_d;
  logic              loading_q, loading_d;
  logic              set_mar_q, set_mar_d;
  logic              set_ram_q, set_ram_d;
  logic [ADDR_W-1:0] addr_init_q, addr_init_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  step_edge u_step_edge (
    .clk      (in_clk),
    .reset    (reset),
    .step_clk (step_clk),
    .step_rise(step_rise)
  );

  // Next state, counters, and outputs decoded from the next state.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (start) begin
      state_d   = ST_SYNC;
      k_d       = '0;
      wd_d      = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SYNC: if (step_rise) state_d = ST_MAR;
        ST_MAR:  if (step_rise) state_d = ST_RAM;
        ST_RAM: begin
          if (step_rise) begin
            if (k_q == K_LAST) begin
              state_d = ST_RUN;
              wd_d    = '0;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = ST_MAR;
            end
          end
        end
        ST_RUN: begin
          if (step_rise) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
              state_d   = ST_IDLE;
              timeout_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cpu_reset_d = 1'b1;
    loading_d   = 1'b0;
    set_mar_d   = 1'b0;
    set_ram_d   = 1'b0;
    addr_init_d = '0;
    instr_d     = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rom_addr_d  = k_d;
    unique case (1'b1)
      (state_d == ST_SYNC): busy_d = 1'b1;
      (state_d == ST_MAR): begin
        busy_d      = 1'b1;
        loading_d   = 1'b1;
        set_mar_d   = 1'b1;
        addr_init_d = k_d;
      end
      (state_d == ST_RAM): begin
        busy_d      = 1'b1;
        loading_d   = 1'b1;
        set_ram_d   = 1'b1;
        addr_init_d = k_d;
        instr_d     = rom_data;
      end
      (state_d == ST_RUN): begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b0;
      set_mar_q   <= 1'b0;
      set_ram_q   <= 1'b0;
      addr_init_q <= '0;
      rom_addr_q  <= '0;
      instr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      set_mar_q   <= set_mar_d;
      set_ram_q   <= set_ram_d;
      addr_init_q <= addr_init_d;
      rom_addr_q  <= rom_addr_d;
      instr_q     <= instr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign cpu_reset      = cpu_reset_q;
  assign loading_ram    = loading_q;
  assign set_mar_init   = set_mar_q;
  assign addr_init      = addr_init_q;
  assign set_ram_init   = set_ram_q;
  assign instr_from_rom = instr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer.
// PROG_LEN=4, WATCHDOG=5, 4-cycle stepper.
module tb_boot_sequencer;

  logic       in_clk = 1'b0;
  logic       reset;
  logic       start;
  logic       step_clk;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       cpu_reset;
  logic       loading_ram;
  logic       set_mar_init;
  logic [7:0] addr_init;
  logic       set_ram_init;
  logic [7:0] instr_from_rom;
  logic       busy;
  logic       done;
  logic       timeout;

  logic [7:0] rom_mem [4];
  logic [7:0] exp_byte [4];
  bit         rand_step;
  int         ph;
  int         nerr;
  int         nchk;

  boot_sequencer #(
    .PROG_LEN(4),
    .WATCHDOG(5)
  ) dut (
    .in_clk        (in_clk),
    .reset         (reset),
    .start         (start),
    .step_clk      (step_clk),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .cpu_reset     (cpu_reset),
    .loading_ram   (loading_ram),
    .set_mar_init  (set_mar_init),
    .addr_init     (addr_init),
    .set_ram_init  (set_ram_init),
    .instr_from_rom(instr_from_rom),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  always #5 in_clk = ~in_clk;

  always_comb begin
    if (rom_addr < 8'd4) rom_data = rom_mem[rom_addr[1:0]];
    else                 rom_data = 8'hEE;
  end

  // Stepper: random while in reset, else 2 high / 2 low.
  initial begin
    step_clk = 1'b0;
    ph = 0;
    forever begin
      @(posedge in_clk);
      #1;
      if (rand_step) begin
        step_clk = 1'($urandom_range(0, 1));
      end else begin
        ph = (ph + 1) % 4;
        step_clk = (ph < 2);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge in_clk);
    #1 start = 1'b1;
    @(posedge in_clk);
    #1 start = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic wait_mar();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (set_mar_init) begin
        ok = 1'b1;
        break;
      end
      @(negedge in_clk);
    end
    chk("mar_seen", 32'(ok), 32'd1);
  endtask

  // Walk the 8 load slots and land on the first RUN cycle.
  task automatic check_load();
    wait_mar();
    for (int k = 0; k < 4; k++) begin
      chk("mar_strobe", 32'(set_mar_init), 32'd1);
      chk("mar_noram", 32'(set_ram_init), 32'd0);
      chk("mar_addr", 32'(addr_init), 32'(k));
      chk("mar_load", 32'(loading_ram), 32'd1);
      repeat (4) @(negedge in_clk);
      chk("ram_strobe", 32'(set_ram_init), 32'd1);
      chk("ram_nomar", 32'(set_mar_init), 32'd0);
      chk("ram_addr", 32'(addr_init), 32'(k));
      chk("ram_rom_addr", 32'(rom_addr), 32'(k));
      chk("ram_instr", 32'(instr_from_rom),
          32'(exp_byte[k]));
      chk("ram_load", 32'(loading_ram), 32'd1);
      chk("ram_cpu_rst", 32'(cpu_reset), 32'd1);
      repeat (4) @(negedge in_clk);
    end
    chk("run_done", 32'(done), 32'd1);
    chk("run_cpu_rst", 32'(cpu_reset), 32'd0);
    chk("run_load", 32'(loading_ram), 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    nerr = 0;
    nchk = 0;
    rom_mem[0] = 8'hA1;
    rom_mem[1] = 8'hB2;
    rom_mem[2] = 8'hC3;
    rom_mem[3] = 8'hD4;
    exp_byte[0] = 8'hA1;
    exp_byte[1] = 8'hB2;
    exp_byte[2] = 8'hC3;
    exp_byte[3] = 8'hD4;
    rand_step = 1'b1;
    reset = 1'b0;
    start = 1'b0;

    // Reset held: start ignored.
    repeat (3) @(posedge in_clk);
    #1 start = 1'b1;
    @(posedge in_clk);
    #1 start = 1'b0;
    repeat (3) @(negedge in_clk);
    chk("rst_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_load", 32'(loading_ram), 32'd0);
    chk("rst_mar", 32'(set_mar_init), 32'd0);
    chk("rst_ram", 32'(set_ram_init), 32'd0);
    chk("rst_addr", 32'(addr_init), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr", 32'(instr_from_rom), 32'd0);

    rand_step = 1'b0;
    @(posedge in_clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge in_clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cpu_rst", 32'(cpu_reset), 32'd1);

    // Full load, then watchdog.
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu_rst", 32'(cpu_reset), 32'd1);
    check_load();
    repeat (19) @(negedge in_clk);
    chk("wd_still_run", 32'(done), 32'd1);
    chk("wd_no_to", 32'(timeout), 32'd0);
    @(negedge in_clk);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("wd_done", 32'(done), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge in_clk);
    chk("wd_sticky", 32'(timeout), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);

    // Restart from IDLE clears timeout.
    pulse_start();
    chk("re_to_clr", 32'(timeout), 32'd0);
    chk("re_busy", 32'(busy), 32'd1);
    check_load();

    // Restart in RUN.
    repeat (3) @(negedge in_clk);
    pulse_start();
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("rr_busy", 32'(busy), 32'd1);
    check_load();

    // Abort during RAM slot k=2.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (set_ram_init && addr_init == 8'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge in_clk);
    end
    chk("ab_ram2_seen", 32'(ok), 32'd1);
    pulse_start();
    chk("ab_ram_drop", 32'(set_ram_init), 32'd0);
    chk("ab_mar_drop", 32'(set_mar_init), 32'd0);
    chk("ab_load_drop", 32'(loading_ram), 32'd0);
    chk("ab_cpu_rst", 32'(cpu_reset), 32'd1);
    wait_mar();
    chk("ab_mar_addr", 32'(addr_init), 32'd0);

    // Async reset during a RAM slot.
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (set_ram_init) begin
        ok = 1'b1;
        break;
      end
      @(negedge in_clk);
    end
    chk("ar_ram_seen", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_ram_drop", 32'(set_ram_init), 32'd0);
    chk("ar_load_drop", 32'(loading_ram), 32'd0);
    chk("ar_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_addr", 32'(addr_init), 32'd0);
    chk("ar_instr", 32'(instr_from_rom), 32'd0);
    @(posedge in_clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge in_clk);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
